// File: rtl/wb_retire_pkg.sv
// Shared defaults and the packed retire-queue entry width for the writeback/retire stage.
package wb_retire_pkg;

    localparam int DEF_DBITS     = 32;
    localparam int DEF_INSTBITS  = 32;
    localparam int DEF_REGNOBITS = 5;
    localparam int DEF_CSRNOBITS = 12;
    localparam int DEF_DEPTH     = 4;

    // Entry layout, MSB to LSB: {pc, inst, wr_reg, rd, rd_val, wr_csr, csrno, csr_val, halt}
    function automatic int wb_entry_width(input int dbits, input int instbits,
                                          input int regnobits, input int csrnobits);
        return 3 * dbits + instbits + regnobits + csrnobits + 3;
    endfunction

endpackage

// File: rtl/wb_retire_fifo.sv
// In-order circular retire queue with per-entry valid bits, flush, and a per-entry
// destination view so the stage can build its pending-register vector.
module wb_retire_fifo
    import wb_retire_pkg::*;
#(
    parameter int WIDTH     = wb_entry_width(DEF_DBITS, DEF_INSTBITS, DEF_REGNOBITS, DEF_CSRNOBITS),
    parameter int DEPTH     = DEF_DEPTH,
    parameter int REGNOBITS = DEF_REGNOBITS,
    parameter int RD_LSB    = 0,
    parameter int WRREG_BIT = 0
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                push,
    input  logic [WIDTH-1:0]                    push_data,
    input  logic                                pop,
    input  logic                                flush,
    output logic [WIDTH-1:0]                    head_data,
    output logic                                head_valid,
    output logic                                full,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy,
    output logic [DEPTH-1:0]                    ent_valid,
    output logic [DEPTH-1:0]                    ent_wr_reg,
    output logic [DEPTH-1:0][REGNOBITS-1:0]     ent_rd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_valid;
    logic [PW-1:0]    r_head;
    logic [PW-1:0]    r_tail;
    logic [CW-1:0]    r_count;

    // Pointers, count and valid bits; a flush (halt) discards everything including a same-cycle push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_valid <= '0;
        end else begin
            if (pop) begin
                r_head          <= r_head + PW'(1);
                r_valid[r_head] <= 1'b0;
            end
            if (push) begin
                r_tail          <= r_tail + PW'(1);
                r_valid[r_tail] <= 1'b1;
            end
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            r_mem[r_tail] <= push_data;
        end
    end

    assign head_data  = r_mem[r_head];
    assign head_valid = r_valid[r_head];
    assign full       = (r_count == CW'(DEPTH));
    assign occupancy  = r_count;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_view
            assign ent_valid[gi]  = r_valid[gi];
            assign ent_wr_reg[gi] = r_mem[gi][WRREG_BIT];
            assign ent_rd[gi]     = r_mem[gi][RD_LSB +: REGNOBITS];
        end
    endgenerate

endmodule

// File: rtl/wb_retire_stage.sv
// Writeback/retire stage: queues MEM results, retires in order from the head, drives
// register-file and CSR writes, tracks pending destinations, instret and sticky halt.
module wb_retire_stage
    import wb_retire_pkg::*;
#(
    parameter int DBITS     = DEF_DBITS,
    parameter int INSTBITS  = DEF_INSTBITS,
    parameter int REGNOBITS = DEF_REGNOBITS,
    parameter int CSRNOBITS = DEF_CSRNOBITS,
    parameter int DEPTH     = DEF_DEPTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DBITS-1:0]             in_pc,
    input  logic [INSTBITS-1:0]          in_inst,
    input  logic                         in_wr_reg,
    input  logic [REGNOBITS-1:0]         in_rd,
    input  logic [DBITS-1:0]             in_rd_val,
    input  logic                         in_wr_csr,
    input  logic [CSRNOBITS-1:0]         in_csrno,
    input  logic [DBITS-1:0]             in_csr_val,
    input  logic                         in_halt,
    output logic                         rf_we,
    output logic [REGNOBITS-1:0]         rf_wregno,
    output logic [DBITS-1:0]             rf_wdata,
    output logic                         csr_we,
    input  logic                         csr_ready,
    output logic [CSRNOBITS-1:0]         csr_wno,
    output logic [DBITS-1:0]             csr_wdata,
    output logic [(2**REGNOBITS)-1:0]    pend_regs,
    output logic                         retire_valid,
    output logic [DBITS-1:0]             retire_pc,
    output logic [INSTBITS-1:0]          retire_inst,
    output logic [63:0]                  instret,
    output logic                         halted,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

    localparam int ENTRY_W    = wb_entry_width(DBITS, INSTBITS, REGNOBITS, CSRNOBITS);
    localparam int HALT_BIT   = 0;
    localparam int CSRVAL_LSB = 1;
    localparam int CSRNO_LSB  = CSRVAL_LSB + DBITS;
    localparam int WRCSR_BIT  = CSRNO_LSB + CSRNOBITS;
    localparam int RDVAL_LSB  = WRCSR_BIT + 1;
    localparam int RD_LSB     = RDVAL_LSB + DBITS;
    localparam int WRREG_BIT  = RD_LSB + REGNOBITS;
    localparam int INST_LSB   = WRREG_BIT + 1;
    localparam int PC_LSB     = INST_LSB + INSTBITS;

    logic                              r_halted;
    logic [63:0]                       r_instret;

    logic [ENTRY_W-1:0]                w_in_entry;
    logic [ENTRY_W-1:0]                w_head;
    logic                              w_head_valid;
    logic                              w_full;
    logic                              w_push;
    logic                              w_retire;
    logic                              w_flush;
    logic [DEPTH-1:0]                  w_ent_valid;
    logic [DEPTH-1:0]                  w_ent_wr_reg;
    logic [DEPTH-1:0][REGNOBITS-1:0]   w_ent_rd;

    logic                              w_h_wr_csr;
    logic                              w_h_wr_reg;
    logic                              w_h_halt;
    logic [REGNOBITS-1:0]              w_h_rd;

    assign w_in_entry = {in_pc, in_inst, in_wr_reg, in_rd, in_rd_val,
                         in_wr_csr, in_csrno, in_csr_val, in_halt};

    assign w_h_wr_csr = w_head[WRCSR_BIT];
    assign w_h_wr_reg = w_head[WRREG_BIT];
    assign w_h_halt   = w_head[HALT_BIT];
    assign w_h_rd     = w_head[RD_LSB +: REGNOBITS];

    // Accept only from registered state; a full queue never takes a push even if the head pops.
    assign in_ready = !w_full && !r_halted;
    assign w_push   = in_valid && in_ready;
    assign w_retire = w_head_valid && !r_halted && (!w_h_wr_csr || csr_ready);
    assign w_flush  = w_retire && w_h_halt;

    wb_retire_fifo #(
        .WIDTH     (ENTRY_W),
        .DEPTH     (DEPTH),
        .REGNOBITS (REGNOBITS),
        .RD_LSB    (RD_LSB),
        .WRREG_BIT (WRREG_BIT)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (w_push),
        .push_data  (w_in_entry),
        .pop        (w_retire),
        .flush      (w_flush),
        .head_data  (w_head),
        .head_valid (w_head_valid),
        .full       (w_full),
        .occupancy  (occupancy),
        .ent_valid  (w_ent_valid),
        .ent_wr_reg (w_ent_wr_reg),
        .ent_rd     (w_ent_rd)
    );

    // Head-driven write/retire outputs; data fields read as zero when the queue is empty.
    always_comb begin
        rf_we        = w_retire && w_h_wr_reg && (w_h_rd != '0);
        csr_we       = w_head_valid && w_h_wr_csr && !r_halted;
        retire_valid = w_retire;
        rf_wregno    = '0;
        rf_wdata     = '0;
        csr_wno      = '0;
        csr_wdata    = '0;
        retire_pc    = '0;
        retire_inst  = '0;
        if (w_head_valid) begin
            rf_wregno   = w_h_rd;
            rf_wdata    = w_head[RDVAL_LSB +: DBITS];
            csr_wno     = w_head[CSRNO_LSB +: CSRNOBITS];
            csr_wdata   = w_head[CSRVAL_LSB +: DBITS];
            retire_pc   = w_head[PC_LSB +: DBITS];
            retire_inst = w_head[INST_LSB +: INSTBITS];
        end
    end

    // Pending destinations: every queued GPR writer marks its register; x0 is never pending.
    always_comb begin
        pend_regs = '0;
        for (int e = 0; e < DEPTH; e++) begin
            if (w_ent_valid[e] && w_ent_wr_reg[e]) begin
                pend_regs[w_ent_rd[e]] = 1'b1;
            end
        end
        pend_regs[0] = 1'b0;
    end

    // Retirement counter and sticky halt, set when a halting entry retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_instret <= '0;
            r_halted  <= 1'b0;
        end else begin
            if (w_retire) begin
                r_instret <= r_instret + 64'd1;
            end
            if (w_flush) begin
                r_halted <= 1'b1;
            end
        end
    end

    assign instret = r_instret;
    assign halted  = r_halted;

endmodule

// File: tb/tb_wb_retire_stage.sv
// Self-checking bench for wb_retire_stage: fixed vector table, directed corner sequences
// and randomized traffic compared against a queue-based reference model.
module tb_wb_retire_stage;

    localparam int DBITS     = 32;
    localparam int INSTBITS  = 32;
    localparam int REGNOBITS = 5;
    localparam int CSRNOBITS = 12;
    localparam int DEPTH     = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_pc;
    logic [31:0]  in_inst;
    logic         in_wr_reg;
    logic [4:0]   in_rd;
    logic [31:0]  in_rd_val;
    logic         in_wr_csr;
    logic [11:0]  in_csrno;
    logic [31:0]  in_csr_val;
    logic         in_halt;
    logic         rf_we;
    logic [4:0]   rf_wregno;
    logic [31:0]  rf_wdata;
    logic         csr_we;
    logic         csr_ready;
    logic [11:0]  csr_wno;
    logic [31:0]  csr_wdata;
    logic [31:0]  pend_regs;
    logic         retire_valid;
    logic [31:0]  retire_pc;
    logic [31:0]  retire_inst;
    logic [63:0]  instret;
    logic         halted;
    logic [2:0]   occupancy;

    always #5 clk = ~clk;

    wb_retire_stage #(
        .DBITS(DBITS), .INSTBITS(INSTBITS), .REGNOBITS(REGNOBITS),
        .CSRNOBITS(CSRNOBITS), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .in_wr_reg(in_wr_reg), .in_rd(in_rd), .in_rd_val(in_rd_val),
        .in_wr_csr(in_wr_csr), .in_csrno(in_csrno), .in_csr_val(in_csr_val),
        .in_halt(in_halt),
        .rf_we(rf_we), .rf_wregno(rf_wregno), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_ready(csr_ready), .csr_wno(csr_wno), .csr_wdata(csr_wdata),
        .pend_regs(pend_regs), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_inst(retire_inst), .instret(instret), .halted(halted), .occupancy(occupancy)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        wr_reg;
        logic [4:0]  rd;
        logic [31:0] rd_val;
        logic        wr_csr;
        logic [11:0] csrno;
        logic [31:0] csr_val;
        logic        halt;
    } ent_t;

    typedef struct {
        logic        v;
        logic        wr_reg;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        wr_csr;
        logic        rdy;
        logic        e_rf_we;
        logic [4:0]  e_wregno;
        logic [31:0] e_wdata;
        logic        e_csr_we;
        logic        e_ret;
        logic [2:0]  e_occ;
        logic [31:0] e_pend;
        logic [63:0] e_instret;
    } vec_t;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model: in-order queue of accepted entries plus halt flag and counter.
    ent_t        mq[$];
    logic        m_halted;
    logic [63:0] m_instret;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v, input ent_t e, input logic rdy);
        in_valid   = v;
        in_pc      = e.pc;
        in_inst    = e.inst;
        in_wr_reg  = e.wr_reg;
        in_rd      = e.rd;
        in_rd_val  = e.rd_val;
        in_wr_csr  = e.wr_csr;
        in_csrno   = e.csrno;
        in_csr_val = e.csr_val;
        in_halt    = e.halt;
        csr_ready  = rdy;
    endtask

    function automatic ent_t mk(input logic [31:0] pc, input logic wr_reg, input logic [4:0] rd,
                                input logic [31:0] rd_val, input logic wr_csr,
                                input logic [11:0] csrno, input logic halt);
        ent_t e;
        e.pc      = pc;
        e.inst    = pc ^ 32'h0000_0013;
        e.wr_reg  = wr_reg;
        e.rd      = rd;
        e.rd_val  = rd_val;
        e.wr_csr  = wr_csr;
        e.csrno   = csrno;
        e.csr_val = ~rd_val;
        e.halt    = halt;
        return e;
    endfunction

    function automatic ent_t rand_ent();
        ent_t e;
        e.pc      = $urandom;
        e.inst    = $urandom;
        e.wr_reg  = 1'($urandom_range(0, 1));
        e.rd      = 5'($urandom_range(0, 7));
        e.rd_val  = $urandom;
        e.wr_csr  = ($urandom_range(0, 3) == 0);
        e.csrno   = 12'($urandom);
        e.csr_val = $urandom;
        e.halt    = ($urandom_range(0, 149) == 0);
        return e;
    endfunction

    // One clock cycle: compare every output against the model at the falling edge,
    // advance the model with this cycle's inputs, then move to just after the rising edge.
    task automatic step();
        ent_t        h;
        ent_t        pushed;
        logic        hv;
        logic        exp_ready;
        logic        exp_ret;
        logic [31:0] exp_pend;
        @(negedge clk);
        hv        = (mq.size() > 0);
        h         = hv ? mq[0] : '0;
        exp_ready = (mq.size() < DEPTH) && !m_halted;
        exp_ret   = hv && !m_halted && (!h.wr_csr || csr_ready);
        exp_pend  = '0;
        foreach (mq[k]) begin
            if (mq[k].wr_reg && mq[k].rd != 5'd0) exp_pend[mq[k].rd] = 1'b1;
        end
        chk("in_ready",     64'(in_ready),     64'(exp_ready));
        chk("occupancy",    64'(occupancy),    64'(mq.size()));
        chk("pend_regs",    64'(pend_regs),    64'(exp_pend));
        chk("retire_valid", 64'(retire_valid), 64'(exp_ret));
        chk("rf_we",        64'(rf_we),        64'(exp_ret && h.wr_reg && h.rd != 5'd0));
        chk("rf_wregno",    64'(rf_wregno),    64'(h.rd));
        chk("rf_wdata",     64'(rf_wdata),     64'(h.rd_val));
        chk("csr_we",       64'(csr_we),       64'(hv && h.wr_csr && !m_halted));
        chk("csr_wno",      64'(csr_wno),      64'(h.csrno));
        chk("csr_wdata",    64'(csr_wdata),    64'(h.csr_val));
        chk("retire_pc",    64'(retire_pc),    64'(h.pc));
        chk("retire_inst",  64'(retire_inst),  64'(h.inst));
        chk("instret",      instret,           m_instret);
        chk("halted",       64'(halted),       64'(m_halted));
        pushed = {in_pc, in_inst, in_wr_reg, in_rd, in_rd_val,
                  in_wr_csr, in_csrno, in_csr_val, in_halt};
        if (exp_ret) begin
            $display("retire pc=%08h inst=%08h rf_we=%0d rd=%0d csr=%0d halt=%0d instret=%0d",
                     h.pc, h.inst, rf_we, h.rd, h.wr_csr, h.halt, m_instret + 64'd1);
            m_instret = m_instret + 64'd1;
            void'(mq.pop_front());
            if (h.halt) begin
                m_halted = 1'b1;
                mq.delete();
            end
        end
        if (in_valid && exp_ready && !(exp_ret && h.halt)) mq.push_back(pushed);
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        mq.delete();
        m_halted  = 1'b0;
        m_instret = '0;
    endtask

    // Reset asserted away from the clock edge, held across two edges.
    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, '0, 1'b1);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    vec_t tbl[10];
    int   halt_cycles;

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 1'b1);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        step();
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Vector table: ADDI x5, write to x0, two x7 writers behind a stalled CSR+GPR entry
        tbl[0] = '{1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 3'd0, 32'h0,     64'd0};
        tbl[1] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd5, 32'h11, 1'b0, 1'b1, 3'd1, 32'h20,    64'd0};
        tbl[2] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 3'd0, 32'h0,     64'd1};
        tbl[3] = '{1'b1, 1'b1, 5'd0, 32'h22, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 3'd0, 32'h0,     64'd1};
        tbl[4] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 32'h22, 1'b0, 1'b1, 3'd1, 32'h0,     64'd1};
        tbl[5] = '{1'b1, 1'b1, 5'd7, 32'hA,  1'b1, 1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 3'd0, 32'h0,     64'd2};
        tbl[6] = '{1'b1, 1'b1, 5'd7, 32'hB,  1'b0, 1'b0, 1'b0, 5'd7, 32'hA,  1'b1, 1'b0, 3'd1, 32'h80,    64'd2};
        tbl[7] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd7, 32'hA,  1'b1, 1'b1, 3'd2, 32'h80,    64'd2};
        tbl[8] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b1, 5'd7, 32'hB,  1'b0, 1'b1, 3'd1, 32'h80,    64'd3};
        tbl[9] = '{1'b0, 1'b0, 5'd0, 32'h0,  1'b0, 1'b1, 1'b0, 5'd0, 32'h0,  1'b0, 1'b0, 3'd0, 32'h0,     64'd4};
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].v, mk(32'h100 + 32'(4 * i), tbl[i].wr_reg, tbl[i].rd, tbl[i].val,
                               tbl[i].wr_csr, 12'h300, 1'b0), tbl[i].rdy);
            @(negedge clk);
            chk("tbl_rf_we",     64'(rf_we),        64'(tbl[i].e_rf_we));
            chk("tbl_rf_wregno", 64'(rf_wregno),    64'(tbl[i].e_wregno));
            chk("tbl_rf_wdata",  64'(rf_wdata),     64'(tbl[i].e_wdata));
            chk("tbl_csr_we",    64'(csr_we),       64'(tbl[i].e_csr_we));
            chk("tbl_retire",    64'(retire_valid), 64'(tbl[i].e_ret));
            chk("tbl_occupancy", 64'(occupancy),    64'(tbl[i].e_occ));
            chk("tbl_pend_regs", 64'(pend_regs),    64'(tbl[i].e_pend));
            chk("tbl_instret",   instret,           tbl[i].e_instret);
            $display("vector %0d: rf_we=%0d rd=%0d data=%08h csr_we=%0d ret=%0d occ=%0d pend=%08h instret=%0d",
                     i, rf_we, rf_wregno, rf_wdata, csr_we, retire_valid, occupancy, pend_regs, instret);
            @(posedge clk);
            #1;
        end

        // CSR stall for six cycles with back-to-back pushes, then in-order drain
        do_reset();
        drive(1'b1, mk(32'h200, 1'b0, 5'd0, 32'h55, 1'b1, 12'h305, 1'b0), 1'b0);
        step();
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, mk(32'h204 + 32'(4 * i), 1'b1, 5'(i + 1), 32'h1000 + 32'(i), 1'b0, 12'h0, 1'b0), 1'b0);
            step();
        end
        chk("stall_occupancy", 64'(occupancy),    64'(DEPTH));
        chk("stall_in_ready",  64'(in_ready),     64'd0);
        chk("stall_retire",    64'(retire_valid), 64'd0);
        drive(1'b0, '0, 1'b1);
        repeat (5) step();
        chk("drain_instret", instret, 64'd4);

        // Halt entry with two younger adds queued behind it
        do_reset();
        drive(1'b1, mk(32'h300, 1'b1, 5'd9, 32'h99, 1'b1, 12'h341, 1'b1), 1'b0);
        step();
        drive(1'b1, mk(32'h304, 1'b1, 5'd3, 32'h33, 1'b0, 12'h0, 1'b0), 1'b0);
        step();
        drive(1'b1, mk(32'h308, 1'b1, 5'd4, 32'h44, 1'b0, 12'h0, 1'b0), 1'b0);
        step();
        drive(1'b1, mk(32'h30C, 1'b1, 5'd5, 32'h55, 1'b0, 12'h0, 1'b0), 1'b1);
        step();
        drive(1'b1, mk(32'h310, 1'b1, 5'd6, 32'h66, 1'b0, 12'h0, 1'b0), 1'b1);
        repeat (4) step();
        chk("halt_halted",    64'(halted),    64'd1);
        chk("halt_occupancy", 64'(occupancy), 64'd0);
        chk("halt_in_ready",  64'(in_ready),  64'd0);
        chk("halt_instret",   instret,        64'd1);

        // Asynchronous reset with three entries queued and a CSR write pending
        do_reset();
        drive(1'b1, mk(32'h400, 1'b1, 5'd1, 32'h77, 1'b1, 12'h300, 1'b0), 1'b0);
        step();
        drive(1'b1, mk(32'h404, 1'b1, 5'd2, 32'h78, 1'b0, 12'h0, 1'b0), 1'b0);
        step();
        drive(1'b1, mk(32'h408, 1'b1, 5'd3, 32'h79, 1'b0, 12'h0, 1'b0), 1'b0);
        step();
        chk("ar_pre_csr_we", 64'(csr_we), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk("ar_rf_we",     64'(rf_we),        64'd0);
        chk("ar_csr_we",    64'(csr_we),       64'd0);
        chk("ar_retire",    64'(retire_valid), 64'd0);
        chk("ar_occupancy", 64'(occupancy),    64'd0);
        chk("ar_pend_regs", 64'(pend_regs),    64'd0);
        chk("ar_csr_wno",   64'(csr_wno),      64'd0);
        chk("ar_retire_pc", 64'(retire_pc),    64'd0);
        drive(1'b0, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("ar_hold_instret", instret,    64'd0);
        chk("ar_hold_rf_we",   64'(rf_we), 64'd0);
        reset = 1'b0;
        model_clear();
        repeat (2) step();

        // Randomized traffic against the model
        do_reset();
        halt_cycles = 0;
        for (int c = 0; c < 1500; c++) begin
            drive(($urandom_range(0, 9) < 7), rand_ent(), ($urandom_range(0, 9) < 7));
            step();
            if (m_halted) begin
                halt_cycles++;
                if (halt_cycles > 3) begin
                    do_reset();
                    halt_cycles = 0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
